reg_access_arbiter: RTL

- Sits between the serial front-ends (SPI peripheral = master 0, I2C peripheral = master 1) and the register bank.
- Replaces the static select mux with a registered two-master arbiter.
- Grants one master at a time, holds a request/ack handshake towards the bank, and returns read data, done and error to the granted master.
- Guards against a hung bank with a cycle timeout and counts timeouts for status readback.

---
 rtl/reg_access_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/reg_access_arbiter.sv
// Two-master register-bank arbiter: grants SPI (m0) or I2C (m1) in round-robin,
// runs a valid/ack access towards the bank and guards it with a cycle timeout.
module reg_access_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int REG_W   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              m0_req,
    input  logic              m0_wr_rdn,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [REG_W-1:0]  m0_wdata,
    output logic [REG_W-1:0]  m0_rdata,
    output logic              m0_done,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_wr_rdn,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [REG_W-1:0]  m1_wdata,
    output logic [REG_W-1:0]  m1_rdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic              bus_valid,
    output logic              bus_wr_rdn,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [REG_W-1:0]  bus_wdata,
    input  logic [REG_W-1:0]  bus_rdata,
    input  logic              bus_ack,
    input  logic              bus_err,
    output logic              grant,
    output logic              busy,
    output logic [7:0]        timeout_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       rr_last;   // master granted most recently; reset to 1 so m0 wins first
    logic [7:0] wait_cnt;

    logic             pick;
    logic             expired;
    logic             complete;
    logic             resp_err;
    logic [REG_W-1:0] resp_data;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        pick = 1'b0;
        if (m0_req && m1_req) begin
            pick = ~rr_last;
        end else if (m1_req) begin
            pick = 1'b1;
        end
    end

    // Error beats ack, and an ack in the expiry cycle beats the timeout.
    always_comb begin
        expired   = (wait_cnt == WAIT_LAST);
        complete  = bus_err || bus_ack || expired;
        resp_err  = bus_err || !bus_ack;
        resp_data = '0;
        if (!bus_err && bus_ack && !bus_wr_rdn) begin
            resp_data = bus_rdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            rr_last     <= 1'b1;
            wait_cnt    <= '0;
            grant       <= 1'b0;
            busy        <= 1'b0;
            timeout_cnt <= '0;
            bus_valid   <= 1'b0;
            bus_wr_rdn  <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            m0_rdata    <= '0;
            m0_done     <= 1'b0;
            m0_err      <= 1'b0;
            m1_rdata    <= '0;
            m1_done     <= 1'b0;
            m1_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ena && (m0_req || m1_req)) begin
                        bus_valid  <= 1'b1;
                        bus_wr_rdn <= pick ? m1_wr_rdn : m0_wr_rdn;
                        bus_addr   <= pick ? m1_addr   : m0_addr;
                        bus_wdata  <= pick ? m1_wdata  : m0_wdata;
                        grant      <= pick;
                        rr_last    <= pick;
                        wait_cnt   <= '0;
                        busy       <= 1'b1;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (complete) begin
                        bus_valid <= 1'b0;
                        state     <= RESP;
                        if (grant) begin
                            m1_done  <= 1'b1;
                            m1_err   <= resp_err;
                            m1_rdata <= resp_data;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_err   <= resp_err;
                            m0_rdata <= resp_data;
                        end
                        if (!bus_err && !bus_ack && timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    m0_done <= 1'b0;
                    m0_err  <= 1'b0;
                    m1_done <= 1'b0;
                    m1_err  <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
